// File: rtl/input_debouncer_if.sv
// ----------------------------------------------------------------------------
// input_debouncer_if
//   Signal bundle between a raw level source and the input_debouncer.
//
//   raw_in      asynchronous raw level (button / switch / external line)
//   clean_out   debounced, registered level (feeds edge_detectors.a)
//   busy        high while a candidate level change is being qualified
//   glitch_cnt  saturating count of rejected candidates
//
//   Modports:
//     master  the side that owns raw_in and observes the debounced result
//     slave   the debouncer itself
// ----------------------------------------------------------------------------
interface input_debouncer_if #(
    parameter int CNT_W = 8
);
    logic             raw_in;
    logic             clean_out;
    logic             busy;
    logic [CNT_W-1:0] glitch_cnt;

    modport master (
        output raw_in,
        input  clean_out,
        input  busy,
        input  glitch_cnt
    );

    modport slave (
        input  raw_in,
        output clean_out,
        output busy,
        output glitch_cnt
    );
endinterface : input_debouncer_if

// File: rtl/input_debouncer.sv
// ----------------------------------------------------------------------------
// input_debouncer
//   Conditions a raw, asynchronous, possibly bouncing level for the
//   edge_detectors stage. raw_in is first synchronised into clk through a
//   SYNC_STAGES-deep flop chain; a four-state FSM then accepts a new level
//   only after it has been seen for DEBOUNCE_CYCLES consecutive samples.
//   Shorter excursions are rejected and counted in glitch_cnt.
//
//   Ports:
//     clk              system clock, rising edge
//     rst              synchronous, active-high reset
//     bus.raw_in       asynchronous raw level
//     bus.clean_out    debounced level, registered
//     bus.busy         1 while a candidate change is being qualified
//     bus.glitch_cnt   rejected-candidate count, saturates at all-ones
//
//   Parameters:
//     SYNC_STAGES      synchroniser depth (>= 2)
//     DEBOUNCE_CYCLES  consecutive stable samples to accept a level (>= 2)
//     CNT_W            glitch_cnt width; must match the interface's CNT_W
//
//   Latency: clean_out changes on the (SYNC_STAGES + DEBOUNCE_CYCLES)th rising
//   edge, counting as edge 1 the first edge that samples the new raw_in level.
// ----------------------------------------------------------------------------
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input_debouncer_if.slave bus
);

    // Qualify counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int QW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [QW-1:0]    QUAL_LAST  = QW'(DEBOUNCE_CYCLES - 1);
    localparam logic [QW-1:0]    QUAL_ONE   = QW'(1);
    localparam logic [CNT_W-1:0] GLITCH_MAX = '1;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q;
    logic [QW-1:0]          cnt_q;
    logic                   clean_q;
    logic                   busy_q;
    logic [CNT_W-1:0]       glitch_q;

    // The FSM only ever looks at the last synchroniser stage.
    assign s = sync_q[SYNC_STAGES-1];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == GLITCH_MAX) ? v : v + CNT_W'(1);
    endfunction

    // ------------------------------------------------------------------------
    // Synchroniser. sync_q[0] is the metastability-catching stage.
    // ------------------------------------------------------------------------
    // NOTE: reset is sampled on the clock edge inside always_ff (synchronous),
    // and every state register uses <= so all flops update from the values
    // they held before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.raw_in};
        end
    end

    // ------------------------------------------------------------------------
    // Qualification FSM. clean_out and busy are registered alongside the
    // state so they follow the state they describe with no combinational
    // path from raw_in.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= STABLE_LO;
            cnt_q    <= '0;
            clean_q  <= 1'b0;
            busy_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            case (state_q)
                STABLE_LO: begin
                    if (s) begin
                        state_q <= CHK_HI;
                        cnt_q   <= QUAL_ONE;
                        busy_q  <= 1'b1;
                    end
                end

                CHK_HI: begin
                    // An abort on the final count still wins: the test for
                    // the old level comes before the accept test.
                    if (!s) begin
                        state_q  <= STABLE_LO;
                        cnt_q    <= '0;
                        busy_q   <= 1'b0;
                        glitch_q <= sat_inc(glitch_q);
                    end else if (cnt_q == QUAL_LAST) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        clean_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + QUAL_ONE;
                    end
                end

                STABLE_HI: begin
                    if (!s) begin
                        state_q <= CHK_LO;
                        cnt_q   <= QUAL_ONE;
                        busy_q  <= 1'b1;
                    end
                end

                CHK_LO: begin
                    if (s) begin
                        state_q  <= STABLE_HI;
                        cnt_q    <= '0;
                        busy_q   <= 1'b0;
                        glitch_q <= sat_inc(glitch_q);
                    end else if (cnt_q == QUAL_LAST) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        clean_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + QUAL_ONE;
                    end
                end

                default: begin
                    state_q <= STABLE_LO;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    clean_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clean_out  = clean_q;
    assign bus.busy       = busy_q;
    assign bus.glitch_cnt = glitch_q;

endmodule : input_debouncer

// File: tb/tb_input_debouncer.sv
// ----------------------------------------------------------------------------
// tb_input_debouncer
//   Directed scenarios plus a randomized burst phase. After every clock edge
//   the DUT outputs are compared against a reference model that tracks the
//   synchroniser as a plain delay line and the qualifier as a run length of
//   samples that disagree with the accepted level.
// ----------------------------------------------------------------------------
module tb_input_debouncer;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int CNT_W           = 8;
    localparam int GLITCH_MAX      = (1 << CNT_W) - 1;
    localparam int LATENCY         = SYNC_STAGES + DEBOUNCE_CYCLES;

    logic clk;
    logic rst;

    input_debouncer_if #(.CNT_W(CNT_W)) bus ();

    input_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    bit sync_m [SYNC_STAGES];
    bit clean_m;
    int run_m;
    int glitch_m;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge of the reference model, given the raw level and reset
    // that were present at that edge.
    task automatic model_edge(input logic r, input logic x);
        bit s_m;
        if (x) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_m[i] = 1'b0;
            clean_m  = 1'b0;
            run_m    = 0;
            glitch_m = 0;
        end else begin
            s_m = sync_m[SYNC_STAGES-1];
            if (s_m != clean_m) begin
                run_m++;
                if (run_m == DEBOUNCE_CYCLES) begin
                    clean_m = s_m;
                    run_m   = 0;
                end
            end else if (run_m != 0) begin
                run_m = 0;
                if (glitch_m < GLITCH_MAX) glitch_m++;
            end
            for (int i = SYNC_STAGES - 1; i > 0; i--) sync_m[i] = sync_m[i-1];
            sync_m[0] = r;
        end
    endtask

    // Drive inputs, take one edge, then compare all outputs 1 ns later.
    task automatic step(input logic r, input logic x);
        bus.raw_in = r;
        rst        = x;
        @(posedge clk);
        model_edge(r, x);
        #1;
        check("clean_out",  32'(bus.clean_out),  32'(clean_m));
        check("busy",       32'(bus.busy),       32'(run_m != 0));
        check("glitch_cnt", 32'(bus.glitch_cnt), 32'(glitch_m));
    endtask

    task automatic hold(input logic r, input int n);
        for (int i = 0; i < n; i++) step(r, 1'b0);
    endtask

    int   len;
    logic lvl;

    initial begin
        bus.raw_in = 1'b0;
        rst        = 1'b1;

        // 1. Reset with raw_in high, then full-latency qualification.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("rst_clean",  32'(bus.clean_out),  32'd0);
        check("rst_busy",   32'(bus.busy),       32'd0);
        check("rst_glitch", 32'(bus.glitch_cnt), 32'd0);
        for (int i = 1; i <= LATENCY; i++) begin
            step(1'b1, 1'b0);
            check("rst_release_latency", 32'(bus.clean_out), 32'(i == LATENCY));
        end

        // 2. Clean step low->high->low; busy for 3 cycles before the rise.
        hold(1'b0, 10);
        check("step_low_settled", 32'(bus.clean_out), 32'd0);
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0);
            check("step_rise",  32'(bus.clean_out), 32'(i >= LATENCY));
            check("step_busy",  32'(bus.busy),
                  32'(i > SYNC_STAGES && i < LATENCY));
        end
        check("step_glitch", 32'(bus.glitch_cnt), 32'd0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b0);
            check("step_fall", 32'(bus.clean_out), 32'(i < LATENCY));
        end

        // 3. Bounce rejection: high 2, low 5, high 1, low thereafter.
        hold(1'b1, 2);
        hold(1'b0, 5);
        hold(1'b1, 1);
        hold(1'b0, 10);
        check("bounce_clean",  32'(bus.clean_out),  32'd0);
        check("bounce_glitch", 32'(bus.glitch_cnt), 32'd2);

        // 4. Toggling then settle high: exactly one rise.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0);
            check("settle_rise", 32'(bus.clean_out), 32'(i >= LATENCY));
        end
        check("settle_glitch", 32'(bus.glitch_cnt), 32'd4);
        hold(1'b0, 10);
        check("settle_back_low", 32'(bus.clean_out), 32'd0);

        // 5. Abort on the final qualify count: s high for exactly
        //    DEBOUNCE_CYCLES-1 samples, then drops just as cnt==3.
        hold(1'b1, DEBOUNCE_CYCLES - 1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            check("boundary_clean", 32'(bus.clean_out), 32'd0);
        end
        check("boundary_glitch", 32'(bus.glitch_cnt), 32'd5);
        check("boundary_idle",   32'(bus.busy),       32'd0);

        // Randomized bursts of random length, checked by the model each edge.
        for (int b = 0; b < 120; b++) begin
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 2 * DEBOUNCE_CYCLES));
            hold(lvl, len);
        end

        // 6. Saturation, then reset while STABLE_HI.
        hold(1'b0, 10);
        for (int i = 0; i < 270; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        hold(1'b0, 4);
        check("sat_glitch", 32'(bus.glitch_cnt), 32'(GLITCH_MAX));
        hold(1'b1, 10);
        check("sat_hold_hi",  32'(bus.clean_out),  32'd1);
        check("sat_no_wrap",  32'(bus.glitch_cnt), 32'(GLITCH_MAX));
        step(1'b1, 1'b1);
        check("rst_hi_clean",  32'(bus.clean_out),  32'd0);
        check("rst_hi_glitch", 32'(bus.glitch_cnt), 32'd0);
        for (int i = 1; i <= LATENCY; i++) begin
            step(1'b1, 1'b0);
            check("requalify", 32'(bus.clean_out), 32'(i == LATENCY));
        end

        // Reset while qualifying a fall (CHK_LO).
        hold(1'b0, SYNC_STAGES + 1);
        check("chk_lo_busy", 32'(bus.busy), 32'd1);
        step(1'b0, 1'b1);
        check("rst_chk_clean", 32'(bus.clean_out), 32'd0);
        check("rst_chk_busy",  32'(bus.busy),      32'd0);
        hold(1'b0, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_input_debouncer
